// File: rtl/sw_lut_eval.sv
`default_nettype none
// ============================================================================
// Module   : sw_lut_eval
// Purpose  : Evaluates NUM_CH run-time-programmable truth tables over NUM_IN
//            synchronised (and optionally debounced) switch inputs and drives
//            one registered LED output per table.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            sw_i              - raw asynchronous switch inputs
//            wr_en_i/wr_ch_i/wr_addr_i/wr_bit_i - single-bit table write port
//            wr_err_o          - one-cycle pulse: write to a missing channel
//            led_o             - registered channel outputs
//            led_chg_o         - one-cycle pulse when led_o changed
//            sw_stable_o       - debounced switch vector
// Options  : SW_LUT_DEBOUNCE_EN - when defined, each synchronised switch bit
//            must hold a new value for DEB_CYCLES cycles before it is
//            accepted; when undefined the synchroniser output is used as-is.
// Revision : 1.0 - initial release
// ============================================================================
module sw_lut_eval #(
  parameter  int unsigned NUM_IN     = 8,
  parameter  int unsigned NUM_CH     = 3,
  parameter  int unsigned DEB_CYCLES = 2000000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] sw_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [NUM_IN-1:0] wr_addr_i,
  input  logic              wr_bit_i,
  output logic              wr_err_o,
  output logic [NUM_CH-1:0] led_o,
  output logic              led_chg_o,
  output logic [NUM_IN-1:0] sw_stable_o
);

  localparam int unsigned TBL_D = 1 << NUM_IN;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser per switch bit
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] sync1_q;
  logic [NUM_IN-1:0] sync2_q;
  logic [NUM_IN-1:0] stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // A debounce window of zero cycles has no meaning; nothing is built for it,
  // the block only documents that DEB_CYCLES is expected to be at least 1.
  if (DEB_CYCLES < 1) begin : g_deb_cycles_zero
  end

`ifdef SW_LUT_DEBOUNCE_EN
  // --------------------------------------------------------------------------
  // Per-bit debounce: a bit is accepted after DEB_CYCLES consecutive cycles of
  // disagreement with the current stable value. The counter restarts from 0
  // on acceptance, so it never exceeds DEB_CYCLES-1 and cannot wrap.
  // --------------------------------------------------------------------------
  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_IN-1:0]            stable_q;
  logic [NUM_IN-1:0]            stable_d;
  logic [NUM_IN-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_IN-1:0][CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
`else
  // Without debounce the second synchroniser stage is the stable vector.
  assign stable = sync2_q;
`endif

  // --------------------------------------------------------------------------
  // Truth tables and write port. A channel index that names no table hits no
  // channel, which is exactly the rejection condition for wr_err.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0][TBL_D-1:0] tbl_q;
  logic [NUM_CH-1:0][TBL_D-1:0] tbl_d;
  logic [NUM_CH-1:0]            wr_hit;
  logic                         wr_err_d;
  logic                         wr_err_q;

  always_comb begin
    tbl_d  = tbl_q;
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = wr_en_i && (wr_ch_i == CH_W'(c));
      if (wr_hit[c]) begin
        tbl_d[c][wr_addr_i] = wr_bit_i;
      end
    end
  end

  assign wr_err_d = wr_en_i && !(|wr_hit);

  // --------------------------------------------------------------------------
  // Evaluation uses the pre-edge table and stable vector, so a write or a
  // stable change shows up on led one edge after it lands.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] led_d;
  logic [NUM_CH-1:0] led_q;
  logic              led_chg_d;
  logic              led_chg_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_eval
    assign led_d[c] = tbl_q[c][stable];
  end

  assign led_chg_d = |(led_d ^ led_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q     <= '0;
      led_q     <= '0;
      led_chg_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      led_q     <= led_d;
      led_chg_q <= led_chg_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign led_o       = led_q;
  assign led_chg_o   = led_chg_q;
  assign wr_err_o    = wr_err_q;
  assign sw_stable_o = stable;

endmodule
`default_nettype wire

// File: tb/tb_sw_lut_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_lut_eval
// Purpose  : Self-checking bench for sw_lut_eval (NUM_IN=8, NUM_CH=3,
//            DEB_CYCLES=4). A history-based behavioural model is compared
//            against the DUT after every clock edge and every reset assertion;
//            directed sequences add hand-computed literal expectations.
//            Honours SW_LUT_DEBOUNCE_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_lut_eval;

  localparam int NUM_IN = 8;
  localparam int NUM_CH = 3;
  localparam int DEB    = 4;
`ifdef SW_LUT_DEBOUNCE_EN
  localparam int LAT    = DEB + 2;   // sw change -> sw_stable edges
`else
  localparam int LAT    = 2;
`endif

  logic              clk;
  logic              rst_n;
  logic [NUM_IN-1:0] sw;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [NUM_IN-1:0] wr_addr;
  logic              wr_bit;
  logic              wr_err;
  logic [NUM_CH-1:0] led;
  logic              led_chg;
  logic [NUM_IN-1:0] sw_stable;

  sw_lut_eval #(
    .NUM_IN     (NUM_IN),
    .NUM_CH     (NUM_CH),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_i        (sw),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_addr_i   (wr_addr),
    .wr_bit_i    (wr_bit),
    .wr_err_o    (wr_err),
    .led_o       (led),
    .led_chg_o   (led_chg),
    .sw_stable_o (sw_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. Stable bits are derived from the raw switch history:
  // a bit flips once the synchronised samples of the last DEB edges all
  // disagree with it. Samples from before a reset do not exist.
  // --------------------------------------------------------------------------
  bit         mtbl [NUM_CH][256];
  logic [7:0] hist [$];
  logic [7:0] m_stable;
  logic [2:0] m_led;
  logic       m_chg;
  logic       m_err;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 256; a++) mtbl[c][a] = 1'b0;
    hist.delete();
    m_stable = '0;
    m_led    = '0;
    m_chg    = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] ln;
    for (int c = 0; c < NUM_CH; c++) ln[c] = mtbl[c][m_stable];
    m_chg = (ln != m_led);
    m_led = ln;
    m_err = wr_en && (wr_ch >= 2'(NUM_CH));
    if (wr_en && wr_ch < 2'(NUM_CH)) mtbl[wr_ch][wr_addr] = wr_bit;
    hist.push_back(sw);
    if (hist.size() > 32) void'(hist.pop_front());
`ifdef SW_LUT_DEBOUNCE_EN
    for (int i = 0; i < NUM_IN; i++) begin
      bit all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        int idx = hist.size() - 3 - k;   // sample taken two edges before
        if (idx < 0) all_diff = 1'b0;
        else if (hist[idx][i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) m_stable[i] = ~m_stable[i];
    end
`else
    m_stable = (hist.size() >= 2) ? hist[hist.size() - 2] : 8'h00;
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (chk_en) begin
        check("model_led",       32'(led),       32'(m_led));
        check("model_led_chg",   32'(led_chg),   32'(m_chg));
        check("model_wr_err",    32'(wr_err),    32'(m_err));
        check("model_sw_stable", 32'(sw_stable), 32'(m_stable));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Inputs change just after a falling edge.
  // --------------------------------------------------------------------------
  task automatic wr(input logic [1:0] ch, input logic [7:0] addr, input logic b);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_addr = addr;
    wr_bit  = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_led;
    rst_n   = 1'b0;
    sw      = 8'hFF;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_addr = '0;
    wr_bit  = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_led",    32'(led),       32'h0);
    check("rst_chg",    32'(led_chg),   32'h0);
    check("rst_wr_err", 32'(wr_err),    32'h0);
    check("rst_stable", 32'(sw_stable), 32'h0);

    // Release with all switches high: stable stays 0 until the window passes.
    rst_n = 1'b1;
    repeat (LAT - 1) begin
      @(negedge clk);
      check("rel_stable_hold", 32'(sw_stable), 32'h0);
      check("rel_led_hold",    32'(led),       32'h0);
    end
    @(negedge clk);
    check("rel_stable_ff", 32'(sw_stable), 32'hFF);

    sw = 8'h00;
    settle();
    check("zero_stable", 32'(sw_stable), 32'h00);

    // ch0 addr 1 = 1, then switch 0 -> 1.
    wr(2'd0, 8'h01, 1'b1);
    check("wr0_no_err", 32'(wr_err), 32'h0);
    sw = 8'h01;
    repeat (LAT - 1) @(negedge clk);
    check("sw01_stable_pre", 32'(sw_stable), 32'h00);
    @(negedge clk);
    check("sw01_stable", 32'(sw_stable), 32'h01);
    check("sw01_led_pre", 32'(led), 32'h0);
    @(negedge clk);
    check("sw01_led",     32'(led),     32'h1);
    check("sw01_chg",     32'(led_chg), 32'h1);
    @(negedge clk);
    check("sw01_chg_end", 32'(led_chg), 32'h0);
    check("sw01_led_hold", 32'(led),    32'h1);

    // Short glitch on sw[0].
    sw = 8'h00;
    settle();
    sw = 8'h01;
    repeat (3) @(negedge clk);
    sw = 8'h00;
    repeat (10) @(negedge clk);
    check("glitch_stable", 32'(sw_stable), 32'h00);
    check("glitch_led",    32'(led),       32'h0);

    // ch1 = majority of sw[2:0], written back-to-back.
    wr(2'd1, 8'h03, 1'b1);
    wr(2'd1, 8'h05, 1'b1);
    wr(2'd1, 8'h06, 1'b1);
    wr(2'd1, 8'h07, 1'b1);
    for (int v = 0; v < 8; v++) begin
      sw = 8'(v);
      repeat (LAT + 1) @(negedge clk);
      check("maj_led1", 32'(led[1]), 32'($countones(v) >= 2));
      check("maj_led0", 32'(led[0]), 32'(v == 1));
    end

    // Valid write then rejected write on consecutive edges.
    wr_en = 1'b1; wr_ch = 2'd2; wr_addr = 8'hFF; wr_bit = 1'b1;
    @(negedge clk);
    check("ch2_no_err", 32'(wr_err), 32'h0);
    wr_ch = 2'd3; wr_addr = 8'h00; wr_bit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("bad_ch_err", 32'(wr_err), 32'h1);
    @(negedge clk);
    check("bad_ch_err_end", 32'(wr_err), 32'h0);

    // Read every table entry back through the switches.
    for (int a = 0; a < 256; a++) begin
      sw = 8'(a);
      repeat (LAT + 1) @(negedge clk);
      exp_led[0] = (a == 1);
      exp_led[1] = (a == 3) || (a == 5) || (a == 6) || (a == 7);
      exp_led[2] = (a == 255);
      check("readback", 32'(led), 32'(exp_led));
    end

    // Mid-run, mid-debounce asynchronous reset.
    sw = 8'h01;
    settle();
    check("pre_rst_led", 32'(led), 32'h1);
    sw = 8'h03;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led",    32'(led),       32'h0);
    check("async_rst_stable", 32'(sw_stable), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("post_rst_stable", 32'(sw_stable), 32'h03);
    check("post_rst_led",    32'(led),       32'h0);

    // Write to the selected entry: led follows two edges later.
    wr(2'd0, 8'h03, 1'b1);
    check("wr_lat_edge1", 32'(led), 32'h0);
    @(negedge clk);
    check("wr_lat_edge2", 32'(led),     32'h1);
    check("wr_lat_chg",   32'(led_chg), 32'h1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sw_lut_eval.md
Name: sw_lut_eval

Overview:
Parametrised, registered successor to the fixed switch-to-LED logic blocks on the Boolean board. Each of NUM_CH output channels evaluates a run-time-programmable truth table over NUM_IN switch inputs. Switch inputs are synchronised and debounced before evaluation. Sits between the board switch pins and the LED pins; tables are written through a simple single-bit write port.

Parameters:
NUM_IN, 8, number of switch inputs, which is also the truth-table address width (table depth 2^NUM_IN)
NUM_CH, 3, number of output channels / LEDs
DEB_CYCLES, 2000000, consecutive clk cycles a synchronised input must differ from its stable value before it is accepted (20 ms at 100 MHz); must be at least 1
CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
sw  input  NUM_IN  raw asynchronous switch inputs
wr_en  input  1  table write strobe, one write per asserted cycle
wr_ch  input  CH_W  target channel
wr_addr  input  NUM_IN  truth-table entry (input combination)
wr_bit  input  1  output value for that entry
wr_err  output  1  one-cycle pulse: write rejected
led  output  NUM_CH  registered channel outputs
led_chg  output  1  one-cycle pulse when any led bit changed on the previous edge
sw_stable  output  NUM_IN  debounced switch vector (debug/visibility)

Behaviour:
- Reset (rst_n low, async): sync flops, stable vector, debounce counters, all table bits, led, led_chg and wr_err clear to 0. Release is synchronous to clk.
- Synchroniser: 2 flops per sw bit; the second stage is sync[i].
- Debounce, per bit i, independent counter:
  - If sync[i]==stable[i], the counter is 0.
  - Otherwise the counter increments each cycle.
  - On the cycle where counter==DEB_CYCLES-1 and the bit still differs, stable[i]<=sync[i] and the counter goes to 0.
  - A mismatch lasting fewer than DEB_CYCLES cycles never reaches stable.
  - Counter width is $clog2(DEB_CYCLES+1). The counter must not wrap.
- Evaluation: led[c] <= table[c][stable] every cycle, using pre-edge table and stable values.
- Latency:
  - sw edge to led: 2 (sync) + DEB_CYCLES + 1 edges.
  - Write to led: a write becomes visible on led 2 edges after the wr_en edge (table updates on edge 1, led on edge 2).
- Write port:
  - wr_en with wr_ch<NUM_CH sets table[wr_ch][wr_addr]<=wr_bit.
  - wr_ch>=NUM_CH performs no write; wr_err=1 for exactly one cycle after that edge.
  - Back-to-back writes are allowed every cycle; there is no backpressure.
- Simultaneous events: a write to the entry currently selected by stable, landing on the same edge a stable bit changes, is not a conflict. led follows the pre-edge rules above, then settles to the new table/stable combination one edge later.
- led_chg <= |(led_next ^ led); it is registered alongside led.
- Reset mid-debounce aborts the count. Reset mid-operation clears tables; software must reprogram.

Optional Feature:
SW_LUT_DEBOUNCE_EN
- Defined: debounce path exactly as above.
- Undefined:
  - stable is driven directly by the sync flops; DEB_CYCLES is ignored and no counters are built.
  - sw-to-led latency is 3 edges.
  - All other behaviour is identical.

Test Plan:
- Reset, then release rst_n with sw=8'hFF -> led=0, led_chg=0, wr_err=0, sw_stable=0 until DEB_CYCLES passes.
- DEB_CYCLES=4, macro defined; write ch0 addr 8'h01 bit 1; set sw 8'h00->8'h01 -> sw_stable=8'h01 6 edges later, led[0]=1 on edge 7, led_chg pulses once on the next edge.
- DEB_CYCLES=4; sw[0] glitch high for 3 cycles then low -> sw_stable and led unchanged, no led_chg.
- Program ch1 as a 3-input majority over sw[2:0] (addrs 3,5,6,7 =1); sweep the stable sw 0..7 -> led[1]=1 exactly for 3,5,6,7.
- NUM_CH=3: write with wr_ch=3 -> wr_err=1 for one cycle, all tables unchanged (led readback over all 256 addresses matches the prior state).
- Macro undefined: sw 8'h00->8'h01 with ch0 addr1=1 -> led[0]=1 on the third edge; assert rst_n low mid-run -> led=0 immediately (asynchronous), tables cleared.
